uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 9600, line baud rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit; even, at least 8.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port res, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port uart_rxd, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS, received word, LSB first on line.
REQ-010 SHALL have port rx_valid, output, 1, rx_data and error flags are valid.
REQ-011 SHALL have port rx_ready, input, 1, consumer accepts the word when high with rx_valid.
REQ-012 SHALL have port frame_err, output, 1, a stop bit sampled low; qualified by rx_valid.
REQ-013 SHALL have port parity_err, output, 1, parity mismatch; qualified by rx_valid.
REQ-014 SHALL have port overrun, output, 1, one-cycle pulse when a completed frame is dropped.

Function
REQ-015 SHALL pass uart_rxd through a two-flop synchroniser; all decisions SHALL use the second flop.
REQ-016 SHALL generate a one-cycle tick every DIV = CLK_FREQ/(UART_BPS*OVERSAMPLE) clocks (truncated, minimum 1).
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE->START on a synchronised falling edge; the tick counter SHALL restart at that edge.
REQ-019 Each bit SHALL be decided by majority of three samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
REQ-020 A START bit decided high SHALL be a false start: return to IDLE, no output, no flags.
REQ-021 DATA SHALL shift in DATA_BITS bits LSB first, then go to PARITY (if compiled in) or STOP.
REQ-022 STOP SHALL sample STOP_BITS bits; any stop bit decided low SHALL set frame_err for that word.
REQ-023 The frame SHALL complete at the majority decision of the last stop bit; state returns to IDLE in the same cycle, so a back-to-back start edge is accepted.
REQ-024 On completion with rx_valid low, or with rx_valid&rx_ready high: rx_data, frame_err and parity_err SHALL load and rx_valid SHALL be high the next cycle; latency = 1 clock after the decision.
REQ-025 rx_valid, rx_data and the flags SHALL hold stable until the cycle after rx_valid&rx_ready.
REQ-026 On completion while rx_valid is high and rx_ready is low: the new word SHALL be dropped, held data kept, and overrun pulsed for exactly one clock.
REQ-027 Words with frame_err or parity_err SHALL still be delivered.

Reset
REQ-028 res high SHALL immediately force IDLE, counters to 0, synchroniser flops to 1, and rx_data, rx_valid, frame_err, parity_err and overrun to 0.
REQ-029 A reset mid-frame SHALL discard the partial frame; reception SHALL resume at the next falling edge after reset release.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: add parameter PARITY_ODD (default 0) and the PARITY state, which samples one bit after the data; parity_err = (XOR of data bits ^ parity bit) != PARITY_ODD.
REQ-031 Macro UART_RX_PARITY_EN undefined: no PARITY state and no PARITY_ODD parameter; DATA goes to STOP; the parity_err port stays present, tied to 0.

Structure
REQ-032 Package uart_pkg SHALL hold the rx state enumeration and the DATA_BITS/STOP_BITS legal-range constants.
REQ-033 Sub-module uart_baud_gen SHALL implement the tick divider of REQ-016 (parameters CLK_FREQ, UART_BPS, OVERSAMPLE; restart input).

Verification
Bench settings: CLK_FREQ=1600000, UART_BPS=10000, OVERSAMPLE=16, so DIV=10.
REQ-034 Send 0xA5, 8N1, rx_ready=1 -> rx_valid high one cycle, rx_data=0xA5, frame_err=0, parity_err=0.
REQ-035 Drive a low glitch lasting 3 ticks -> no rx_valid; the FSM is back in IDLE; a following 0x3C frame is received correctly.
REQ-036 Send 0x3C with stop bit low -> rx_valid=1, rx_data=0x3C, frame_err=1.
REQ-037 Send 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data stays 0x11 and overrun pulses once at 0x22 completion; with rx_ready=1 in the completion cycle, 0x22 loads and there is no overrun.
REQ-038 With UART_RX_PARITY_EN and PARITY_ODD=0, send 0x07 with parity bit 0 -> parity_err=1; send 0x07 with parity bit 1 -> parity_err=0.
REQ-039 Assert res during data bit 4 of 0xFF -> all outputs 0 at once; after release, 0x5A is received intact.

Source files
------------

// File: rtl/uart_pkg.sv
// Definitions shared by the UART receiver: FSM states, legal frame ranges and a bit-voting helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    RX_PARITY = 3'd3,
`endif
    RX_STOP   = 3'd4
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick divider: one-cycle tick every CLK_FREQ/(UART_BPS*OVERSAMPLE) clocks (min 1),
// phase-aligned by restart_i so the first tick lands a full period after a start edge.
module uart_baud_gen #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic res,
  input  logic restart_i,
  output logic tick_o
);

  localparam int DIV_RAW = CLK_FREQ / (UART_BPS * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_LAST) && !restart_i;

  // NOTE: every combinational output gets a value on every path, otherwise a latch is inferred.
  always_comb begin
    if (restart_i || cnt_q == CNT_LAST) cnt_d = '0;
    else                                cnt_d = cnt_q + CW'(1);
  end

  // NOTE: flops use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or posedge res) begin
    if (res) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with valid/ready output, frame error and overrun reporting.
// Define UART_RX_PARITY_EN to add a parity bit (PARITY_ODD selects odd parity).
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int IW = $clog2(OVERSAMPLE);
  localparam logic [IW-1:0] IDX_S0  = IW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] IDX_S1  = IW'(OVERSAMPLE / 2);
  localparam logic [IW-1:0] IDX_S2  = IW'(OVERSAMPLE / 2 + 1);
  localparam logic [IW-1:0] IDX_END = IW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, sync2_q, prev_q;
  logic [IW-1:0]        tick_idx_q, tick_idx_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 stop_err_q, stop_err_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, start_edge, bit_decide, bit_end, bit_val;
  logic                 restart, shift_en, stop_en, frame_done;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bit_q, parity_bit_d;
  logic                 parity_err_q, parity_err_d;
  logic                 par_en;
`endif

  // Synchroniser resets to the idle level so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rxd;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  uart_baud_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .UART_BPS   (UART_BPS),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud_gen (
    .clk       (clk),
    .res       (res),
    .restart_i (restart),
    .tick_o    (tick)
  );

  assign start_edge = prev_q & ~sync2_q;
  assign bit_decide = tick && (tick_idx_q == IDX_S2);
  assign bit_end    = tick && (tick_idx_q == IDX_END);
  assign bit_val    = majority3(samp_q[0], samp_q[1], sync2_q);

  always_ff @(posedge clk or posedge res) begin
    if (res) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:   if (start_edge) state_d = RX_START;
      RX_START: begin
        if (bit_decide && bit_val) state_d = RX_IDLE;
        else if (bit_end)          state_d = RX_DATA;
      end
`ifdef UART_RX_PARITY_EN
      RX_DATA:   if (bit_end && bit_cnt_q == LAST_DATA) state_d = RX_PARITY;
      RX_PARITY: if (bit_end) state_d = RX_STOP;
`else
      RX_DATA:   if (bit_end && bit_cnt_q == LAST_DATA) state_d = RX_STOP;
`endif
      // The frame ends mid last stop bit so a back-to-back start edge is not missed.
      RX_STOP:   if (bit_decide && bit_cnt_q == LAST_STOP) state_d = RX_IDLE;
      default:   state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    restart    = 1'b0;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
    frame_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en     = 1'b0;
`endif
    case (state_q)
      RX_IDLE:   restart  = start_edge;
      RX_DATA:   shift_en = bit_decide;
`ifdef UART_RX_PARITY_EN
      RX_PARITY: par_en   = bit_decide;
`endif
      RX_STOP: begin
        stop_en    = bit_decide;
        frame_done = bit_decide && (bit_cnt_q == LAST_STOP);
      end
      default: ;
    endcase
  end

  always_comb begin
    tick_idx_d = tick_idx_q;
    bit_cnt_d  = bit_cnt_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    stop_err_d = stop_err_q;
`ifdef UART_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    if (par_en) parity_bit_d = bit_val;
`endif
    if (restart) tick_idx_d = '0;
    else if (tick && state_q != RX_IDLE)
      tick_idx_d = (tick_idx_q == IDX_END) ? '0 : tick_idx_q + IW'(1);
    if (state_d != state_q) bit_cnt_d = '0;
    else if (bit_end)       bit_cnt_d = bit_cnt_q + 4'd1;
    if (tick && tick_idx_q == IDX_S0) samp_d[0] = sync2_q;
    if (tick && tick_idx_q == IDX_S1) samp_d[1] = sync2_q;
    if (shift_en) shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
    if (restart)                  stop_err_d = 1'b0;
    else if (stop_en && !bit_val) stop_err_d = 1'b1;
  end

  // A held word is only replaced when the consumer takes it in the completion cycle.
  always_comb begin
    rx_data_d   = rx_data_q;
    frame_err_d = frame_err_q;
    rx_valid_d  = rx_valid_q && !rx_ready;
    overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (frame_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d   = shift_q;
        frame_err_d = stop_err_q | ~bit_val;
        rx_valid_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
        parity_err_d = ((^shift_q) ^ parity_bit_q) != PARITY_ODD;
`endif
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      tick_idx_q  <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= 2'b11;
      shift_q     <= '0;
      stop_err_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      tick_idx_q  <= tick_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      stop_err_q  <= stop_err_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: vector table, corner-case sequences and random frames
// scored against a word-level reference model. Parity cases run when UART_RX_PARITY_EN is defined.
module tb_uart_rx_cfg;

  localparam int BIT_CLKS = 160;  // 1600000 / 10000
  localparam int DIV      = 10;
  localparam int OS       = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ODD  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, overrun;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int ovr_cnt = 0;
  logic prev_valid = 1'b0;
  logic [9:0] got_q[$];   // {parity_err, frame_err, data}
  logic [9:0] exp_q[$];

  uart_rx_cfg #(
    .CLK_FREQ   (1600000),
    .UART_BPS   (10000),
    .DATA_BITS  (8),
    .STOP_BITS  (1),
    .OVERSAMPLE (OS)
`ifdef UART_RX_PARITY_EN
    , .PARITY_ODD (PAR_ODD)
`endif
  ) dut (
    .clk        (clk),
    .res        (res),
    .uart_rxd   (uart_rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor on the falling edge: handshaken words, valid rises, overrun cycles.
  always @(negedge clk) begin
    if (res) begin
      prev_valid <= 1'b0;
    end else begin
      if (rx_valid && !prev_valid) begin
        rise_cnt <= rise_cnt + 1;
        rise_cyc <= cyc;
      end
      if (rx_valid && rx_ready) got_q.push_back({parity_err, frame_err, rx_data});
      if (overrun) ovr_cnt <= ovr_cnt + 1;
      prev_valid <= rx_valid;
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted before the end of the test");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line_bit(input logic v);
    uart_rxd = v;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input logic pbit);
    start_cyc = cyc;
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    line_bit(pbit);
`endif
    line_bit(stop_lvl);
    uart_rxd = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ PAR_ODD;
`else
    return ^d;
`endif
  endfunction

  task automatic expect_word(input string name, input logic [7:0] d, input logic fe, input logic pe);
    logic [9:0] w;
    check({name, " delivered"}, got_q.size() > 0, 1);
    if (got_q.size() > 0) begin
      w = got_q.pop_front();
      check({name, " data"}, w[7:0], d);
      check({name, " frame_err"}, w[8], fe);
      check({name, " parity_err"}, w[9], pe);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, " rx_valid"}, rx_valid, 0);
    check({name, " rx_data"}, rx_data, 0);
    check({name, " frame_err"}, frame_err, 0);
    check({name, " parity_err"}, parity_err, 0);
    check({name, " overrun"}, overrun, 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop_lvl;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];
  int   lat;
  int   ovr0, rise0;

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
    vecs[2] = '{8'h01, 1'b1, 8'h01, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b0};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b1};
    vecs[5] = '{8'h4E, 1'b1, 8'h4E, 1'b0};

    // Reset state
    wait_clks(3);
    check_all_zero("reset");
    res = 1'b0;
    wait_clks(50);
    rx_ready = 1'b1;

    // 0xA5 8N1: single valid cycle and completion latency
    rise0 = rise_cnt;
    send_frame(8'hA5, 1'b1, good_par(8'hA5));
    wait_clks(100);
    expect_word("a5", 8'hA5, 1'b0, 1'b0);
    check("a5 single valid", rise_cnt - rise0, 1);
    check("a5 valid dropped", rx_valid, 0);
    lat = rise_cyc - start_cyc;
    check("a5 latency window", (lat >= 9 * BIT_CLKS + (OS / 2) * DIV - 40) &&
                               (lat <= 9 * BIT_CLKS + (OS / 2) * DIV + 40), 1);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].stop_lvl, good_par(vecs[i].data));
      wait_clks(60);
      expect_word($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_fe, 1'b0);
    end

    // Glitch of 3 ticks is a false start; the next frame still lands
    rise0 = rise_cnt;
    uart_rxd = 1'b0;
    wait_clks(3 * DIV);
    uart_rxd = 1'b1;
    wait_clks(100);
    check("glitch no word", got_q.size(), 0);
    check("glitch no valid", rise_cnt - rise0, 0);
    send_frame(8'h3C, 1'b1, good_par(8'h3C));
    wait_clks(60);
    expect_word("post glitch", 8'h3C, 1'b0, 1'b0);

    // Back-to-back with consumer stalled: 0x22 dropped with one overrun cycle
    rx_ready = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b1, good_par(8'h11));
    send_frame(8'h22, 1'b1, good_par(8'h22));
    wait_clks(60);
    check("ovr valid held", rx_valid, 1);
    check("ovr data held", rx_data, 8'h11);
    check("ovr one pulse", ovr_cnt - ovr0, 1);
    rx_ready = 1'b1;
    wait_clks(1);
    rx_ready = 1'b0;
    wait_clks(2);
    expect_word("ovr drain", 8'h11, 1'b0, 1'b0);
    check("ovr valid cleared", rx_valid, 0);

    // Consumer accepts exactly in the completion cycle: 0x22 loads, no overrun
    ovr0 = ovr_cnt;
    send_frame(8'h11, 1'b1, good_par(8'h11));
    fork
      send_frame(8'h22, 1'b1, good_par(8'h22));
      begin
        wait_clks(lat - 1);
        rx_ready = 1'b1;
        wait_clks(1);
        rx_ready = 1'b0;
      end
    join
    wait_clks(60);
    check("same-cycle no overrun", ovr_cnt - ovr0, 0);
    expect_word("same-cycle old", 8'h11, 1'b0, 1'b0);
    check("same-cycle valid", rx_valid, 1);
    check("same-cycle new data", rx_data, 8'h22);
    rx_ready = 1'b1;
    wait_clks(3);
    expect_word("same-cycle drain", 8'h22, 1'b0, 1'b0);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    wait_clks(60);
    expect_word("parity bad", 8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_clks(60);
    expect_word("parity good", 8'h07, 1'b0, 1'b0);
`endif

    // Reset during data bit 4 of 0xFF with a word held
    rx_ready = 1'b0;
    send_frame(8'h81, 1'b1, good_par(8'h81));
    wait_clks(60);
    check("held before reset", rx_valid, 1);
    fork
      send_frame(8'hFF, 1'b1, good_par(8'hFF));
      begin
        wait_clks(5 * BIT_CLKS + BIT_CLKS / 2);
        res = 1'b1;
        #2;
        check_all_zero("mid-frame reset");
        wait_clks(10);
        res = 1'b0;
      end
    join
    rx_ready = 1'b1;
    wait_clks(200);
    check("partial discarded", got_q.size(), 0);
    check("no valid after reset", rx_valid, 0);
    send_frame(8'h5A, 1'b1, good_par(8'h5A));
    wait_clks(60);
    expect_word("after reset", 8'h5A, 1'b0, 1'b0);

    // Random frames against the word-level model
    got_q.delete();
    exp_q.delete();
    ovr0 = ovr_cnt;
    for (int n = 0; n < 16; n++) begin
      logic [7:0] d;
      logic       stp, pb, pe;
      int         gap;
      d   = 8'($urandom_range(0, 255));
      stp = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      pb  = 1'($urandom_range(0, 1));
      pe  = ((^d) ^ pb) != PAR_ODD;
`else
      pb  = 1'b0;
      pe  = 1'b0;
`endif
      exp_q.push_back({pe, ~stp, d});
      send_frame(d, stp, pb);
      gap = stp ? int'($urandom_range(0, 100)) : BIT_CLKS + int'($urandom_range(0, 100));
      if (gap > 0) wait_clks(gap);
    end
    wait_clks(100);
    check("random word count", got_q.size(), exp_q.size());
    check("random no overrun", ovr_cnt - ovr0, 0);
    for (int n = 0; got_q.size() > 0 && exp_q.size() > 0; n++) begin
      logic [9:0] g, e;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check($sformatf("random word %0d", n), g, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
